// File: rtl/tff_cnt_ctrl.sv
// Toggle-vector controller for a WIDTH-bit T flip-flop bank: modulo-MODULUS up/down count, load, hold.
// Optional bank self-check (chk_err) enabled by defining TFF_CTRL_CHECK_EN.
module tff_cnt_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t,
    output logic             running,
    output logic             tc,
`ifdef TFF_CTRL_CHECK_EN
    output logic             chk_err,
`endif
    output logic [7:0]       wrap_cnt
);

    localparam int unsigned    CW    = WIDTH + 1;
    localparam logic [CW-1:0]  MOD_X = CW'(MODULUS);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    state_t           r_ret, w_ret_nxt;
    logic [WIDTH-1:0] r_load, w_load_nxt, w_load_sat;
    logic [WIDTH-1:0] w_inc, w_dec;
    logic             w_wrap, w_illegal;
    logic             r_running, r_tc;
    logic [7:0]       r_wrap_cnt;

    // Increment/decrement toggle vectors via ripple AND of lower bits
    always_comb begin
        logic carry_u;
        logic carry_d;
        carry_u = 1'b1;
        carry_d = 1'b1;
        w_inc   = '0;
        w_dec   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_inc[i] = carry_u;
            w_dec[i] = carry_d;
            carry_u  = carry_u & q_in[i];
            carry_d  = carry_d & ~q_in[i];
        end
    end

    assign w_illegal  = {1'b0, q_in} >= MOD_X;
    assign w_load_sat = ({1'b0, load_val} >= MOD_X) ? TOP : load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
            r_load  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_load  <= w_load_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_load_nxt  = r_load;
        w_wrap      = 1'b0;
        t           = '0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_LOAD;
                    w_ret_nxt   = S_IDLE;
                    w_load_nxt  = w_load_sat;
                end else if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (load) begin
                    w_state_nxt = S_LOAD;
                    w_ret_nxt   = S_RUN;
                    w_load_nxt  = w_load_sat;
                end else if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (en) begin
                    // Out-of-range bank state is forced back to zero without counting a wrap
                    if (w_illegal) begin
                        t = q_in;
                    end else if (up) begin
                        if (q_in == TOP) begin
                            t      = q_in;
                            w_wrap = 1'b1;
                        end else begin
                            t = w_inc;
                        end
                    end else begin
                        if (q_in == '0) begin
                            t      = TOP;
                            w_wrap = 1'b1;
                        end else begin
                            t = w_dec;
                        end
                    end
                end
            end
            S_LOAD: begin
                t           = q_in ^ r_load;
                w_state_nxt = r_ret;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_running  <= 1'b0;
            r_tc       <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_running <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LOAD);
            r_tc      <= w_wrap;
            if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
            end
        end
    end

    assign running  = r_running;
    assign tc       = r_tc;
    assign wrap_cnt = r_wrap_cnt;

`ifdef TFF_CTRL_CHECK_EN
    logic [WIDTH-1:0] r_exp_q;
    logic             r_arm;
    logic             r_chk_err;

    // Bank must equal last cycle's q_in ^ t; first edge after reset only primes exp_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_q   <= '0;
            r_arm     <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            r_exp_q <= q_in ^ t;
            r_arm   <= 1'b1;
            if (r_arm && (q_in != r_exp_q)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule

// File: doc/tff_cnt_ctrl.md
Name: tff_cnt_ctrl

Overview:
- Toggle-vector controller that sits directly upstream of a bank of WIDTH T flip-flops.
- Reads the bank's present state q_in and drives the bank's t inputs, so the bank counts modulo MODULUS (up or down), loads a value, or holds.
- Owns the control FSM, a terminal-count pulse and a wrap counter.
- Bank and controller share clk and rst.

Parameters:
- WIDTH, 4, counter bit width. Range 2..16.
- MODULUS, 10, count modulus. Range 2..2**WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  pulse; IDLE->RUN
- stop  input  1  pulse; RUN->IDLE
- en  input  1  count enable in RUN
- up  input  1  1 = count up, 0 = count down
- load  input  1  pulse; request load of load_val
- load_val  input  WIDTH  value to load
- q_in  input  WIDTH  present state of the TFF bank
- t  output  WIDTH  toggle vector to the TFF bank; combinational from state and q_in
- running  output  1  registered; 1 while state is RUN or LOAD
- tc  output  1  registered; one-cycle terminal-count pulse
- wrap_cnt  output  8  registered; saturating count of wraps

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- While rst=0: state=IDLE, running=0, tc=0, wrap_cnt=0, load_reg=0, t=0.
- FSM states: IDLE, RUN, LOAD.
- Command priority in IDLE/RUN: load > stop > start.
- IDLE:
  - t=0.
  - load -> LOAD, return target IDLE.
  - start -> RUN.
- RUN:
  - load -> LOAD, return target RUN.
  - stop -> IDLE; t=0 in that cycle.
  - Otherwise, if en=0: t=0 (hold).
  - Otherwise, if en=1 and up=1:
    - q_in==MODULUS-1: t=q_in (bank -> 0); wrap event.
    - else: t[0]=1, t[i]=&q_in[i-1:0] (increment).
  - Otherwise, if en=1 and up=0:
    - q_in==0: t=MODULUS-1 (bank -> MODULUS-1); wrap event.
    - else: t[0]=1, t[i]=&~q_in[i-1:0] (decrement).
  - Illegal q_in (>=MODULUS) with en=1: t=q_in (bank -> 0); no wrap event.
- Load capture:
  - On the load cycle, load_reg <= load_val, saturated to MODULUS-1 if load_val>=MODULUS.
- LOAD:
  - Lasts exactly one cycle; t=q_in^load_reg, so the bank equals load_reg after the edge.
  - Commands are ignored in LOAD.
  - Next state is the return target.
- Latency:
  - The bank changes on the same edge at which t is sampled.
  - A load pulse at edge N is visible on the bank after edge N+1.
- tc: asserted for the one cycle following the edge at which a wrap event is sampled. Back-to-back wraps (MODULUS=2) give tc high on consecutive cycles.
- wrap_cnt: +1 per wrap event; saturates at 255; cleared only by reset.
- running: registered from the next state; 1 in RUN and LOAD.
- Reset mid-operation: asynchronous return to IDLE. An in-flight load is discarded. The bank resets together with the controller.
- Simultaneous start+stop in IDLE: stop wins, so the FSM stays in IDLE.

Optional Feature:
- Macro: TFF_CTRL_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, sticky, reset 0) and a register exp_q (reset 0).
  - Each cycle exp_q <= q_in^t.
  - From the second cycle after reset deassertion, if q_in!=exp_q, chk_err <= 1 until reset.
  - Detects a faulty or stalled bank.
- Undefined: no chk_err port, no exp_q logic; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 then 1, no commands, 5 clks -> t=0, running=0, tc=0, wrap_cnt=0, q stays 0.
- Up wrap: MODULUS=10, start, en=1, up=1 for 12 clks -> q sequence 0..9,0,1; single tc pulse one cycle after q 9->0; wrap_cnt=1.
- Down wrap: from q=0 in RUN, en=1, up=0, 3 clks -> q 9,8,7; tc pulses once; wrap_cnt +1.
- Load + priority: in RUN at q=3, load=1, stop=1, load_val=13 -> LOAD next cycle, q=9 (saturated), then RUN (stop ignored); subsequent up count wraps to 0.
- Hold/stop/reset mid-op: en=0 at q=5 for 3 clks -> q=5 held; stop -> IDLE, t=0; start, count to q=7, assert rst mid-cycle -> q=0, state IDLE immediately.
- TFF_CTRL_CHECK_EN: force the bank's t input low for one cycle while in RUN -> chk_err=1 next cycle and stays 1 until reset.
